// File: rtl/gpio_pkg.sv
// Register map, address field positions and byte-lane helper shared by the
// GPIO controller top level and its per-port register blocks.
package gpio_pkg;

  localparam int ADDR_W     = 9;
  localparam int GLOBAL_BIT = 8;
  localparam int PORT_LSB   = 5;
  localparam int PORT_W     = 3;
  localparam int REG_LSB    = 2;
  localparam int REG_W      = 3;

  typedef enum logic [REG_W-1:0] {
    REG_OUT     = 3'd0,
    REG_OE      = 3'd1,
    REG_IN      = 3'd2,
    REG_RISE_EN = 3'd3,
    REG_FALL_EN = 3'd4,
    REG_STATUS  = 3'd5
  } port_reg_e;

  typedef enum logic [REG_W-1:0] {
    REG_DIV   = 3'd0,
    REG_TICKS = 3'd1
  } glob_reg_e;

  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = {8{strb[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_port.sv
// One GPIO port: OUT/OE/enable registers, input synchroniser with history
// flop, rise/fall edge detection and sticky W1C status.
module gpio_port
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  port_reg_e        reg_sel,
  input  logic [31:0]      wdata,
  input  logic [31:0]      wmask,
  input  logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] out_o,
  output logic [WIDTH-1:0] oe_o,
  output logic [31:0]      rdata,
  output logic             irq
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] oe_q, oe_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;

  logic [WIDTH-1:0] wd, wm, cur, rise, fall, clr;

  assign wd   = wdata[WIDTH-1:0];
  assign wm   = wmask[WIDTH-1:0];
  assign cur  = sync_q[SYNC_STAGES-1];
  assign rise = cur & ~prev_q;
  assign fall = ~cur & prev_q;

  always_comb begin
    out_d     = out_q;
    oe_d      = oe_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    clr       = '0;
    if (wr_en) begin
      case (reg_sel)
        REG_OUT:     out_d     = (out_q & ~wm) | (wd & wm);
        REG_OE:      oe_d      = (oe_q & ~wm) | (wd & wm);
        REG_RISE_EN: rise_en_d = (rise_en_q & ~wm) | (wd & wm);
        REG_FALL_EN: fall_en_d = (fall_en_q & ~wm) | (wd & wm);
        REG_STATUS:  clr       = wd & wm;
        default:     ;
      endcase
    end
    // A new edge wins over a concurrent clear so no event is ever lost.
    status_d = (status_q & ~clr) | (rise & rise_en_q) | (fall & fall_en_q);
    sync_d   = {sync_q[SYNC_STAGES-2:0], pad_i};
    prev_d   = cur;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_q     <= '0;
      oe_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      prev_q    <= '0;
      sync_q    <= '0;
    end else begin
      out_q     <= out_d;
      oe_q      <= oe_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      prev_q    <= prev_d;
      sync_q    <= sync_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_OUT:     rdata[WIDTH-1:0] = out_q;
      REG_OE:      rdata[WIDTH-1:0] = oe_q;
      REG_IN:      rdata[WIDTH-1:0] = cur;
      REG_RISE_EN: rdata[WIDTH-1:0] = rise_en_q;
      REG_FALL_EN: rdata[WIDTH-1:0] = fall_en_q;
      REG_STATUS:  rdata[WIDTH-1:0] = status_q;
      default:     ;
    endcase
  end

  assign out_o = out_q;
  assign oe_o  = oe_q;
  assign irq   = |status_q;

endmodule

// File: rtl/mmio_gpio_ctrl.sv
// Memory-mapped GPIO controller: address decode, combinational read mux,
// NUM_PORTS port blocks, programmable tick divider and interrupt OR.
module mmio_gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DIV_W       = 24,
  parameter int DIV_RESET   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sel,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [31:0]                wdata,
  input  logic [3:0]                 wstrb,
  output logic [31:0]                rdata,
  input  logic [NUM_PORTS*WIDTH-1:0] gpio_i,
  output logic [NUM_PORTS*WIDTH-1:0] gpio_o,
  output logic [NUM_PORTS*WIDTH-1:0] gpio_oe,
  output logic                       irq_o,
  output logic                       tick_o
);

  logic              is_global;
  logic [PORT_W-1:0] port_idx;
  logic [REG_W-1:0]  reg_idx;
  port_reg_e         port_reg;
  logic              wr_any;
  logic [31:0]       wmask;
  logic              unused_addr;

  assign is_global   = addr[GLOBAL_BIT];
  assign port_idx    = addr[PORT_LSB +: PORT_W];
  assign reg_idx     = addr[REG_LSB +: REG_W];
  assign port_reg    = port_reg_e'(reg_idx);
  assign wr_any      = sel && we;
  assign wmask       = strb_to_mask(wstrb);
  assign unused_addr = ^addr[1:0];

  logic [NUM_PORTS-1:0] port_wr;
  logic [NUM_PORTS-1:0] port_irq;
  logic [31:0]          port_rdata [NUM_PORTS];

  // Port indices at or above NUM_PORTS match no instance, so writes there vanish.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign port_wr[p] = wr_any && !is_global && (port_idx == PORT_W'(p));

    gpio_port #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_port (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (port_wr[p]),
      .reg_sel (port_reg),
      .wdata   (wdata),
      .wmask   (wmask),
      .pad_i   (gpio_i[p*WIDTH +: WIDTH]),
      .out_o   (gpio_o[p*WIDTH +: WIDTH]),
      .oe_o    (gpio_oe[p*WIDTH +: WIDTH]),
      .rdata   (port_rdata[p]),
      .irq     (port_irq[p])
    );
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [31:0]      ticks_q, ticks_d;
  logic             div_wr;

  assign div_wr = wr_any && is_global && (reg_idx == REG_DIV);
  assign tick_o = (cnt_q == div_q);

  always_comb begin
    div_d = div_q;
    if (div_wr) begin
      div_d = (div_q & ~wmask[DIV_W-1:0]) | (wdata[DIV_W-1:0] & wmask[DIV_W-1:0]);
    end
    // Reprogramming restarts the period so the first tick is a full period away.
    if (div_wr || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
    ticks_d = ticks_q + (tick_o ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q   <= DIV_W'(DIV_RESET);
      cnt_q   <= '0;
      ticks_q <= '0;
    end else begin
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      ticks_q <= ticks_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      if (is_global) begin
        case (glob_reg_e'(reg_idx))
          REG_DIV:   rdata[DIV_W-1:0] = div_q;
          REG_TICKS: rdata = ticks_q;
          default:   ;
        endcase
      end else begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (port_idx == PORT_W'(p)) begin
            rdata = port_rdata[p];
          end
        end
      end
    end
  end

  assign irq_o = |port_irq;

endmodule

// File: tb/tb_mmio_gpio_ctrl.sv
// Directed bench for mmio_gpio_ctrl with a register-map level reference model
// checked every cycle, plus literal expectations from the register map rules.
module tb_mmio_gpio_ctrl;

  localparam int NP   = 2;
  localparam int W    = 32;
  localparam int S    = 2;
  localparam int DW   = 24;
  localparam int DIVR = 2;
  localparam logic [31:0] DIV_MASK = (32'd1 << DW) - 32'd1;

  logic          clk = 1'b0;
  logic          rst, sel, we;
  logic [8:0]    addr;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic [31:0]   rdata;
  logic [NP*W-1:0] gpio_i, gpio_o, gpio_oe;
  logic          irq_o, tick_o;

  always #5 clk = ~clk;

  mmio_gpio_ctrl #(
    .NUM_PORTS(NP), .WIDTH(W), .SYNC_STAGES(S), .DIV_W(DW), .DIV_RESET(DIVR)
  ) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata), .gpio_i(gpio_i), .gpio_o(gpio_o),
    .gpio_oe(gpio_oe), .irq_o(irq_o), .tick_o(tick_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: register contents plus the pad history as seen at each edge.
  logic [W-1:0]    m_out [NP];
  logic [W-1:0]    m_oe  [NP];
  logic [W-1:0]    m_ren [NP];
  logic [W-1:0]    m_fen [NP];
  logic [W-1:0]    m_st  [NP];
  logic [NP*W-1:0] m_hist [S+1];
  logic [31:0]     m_div, m_ticks;
  longint          m_k;
  bit              m_valid = 1'b0;

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    logic [31:0] m;
    m = 32'd0;
    for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8*b));
    return m;
  endfunction

  function automatic bit m_tick();
    return (m_k % (longint'(m_div) + 1)) == longint'(m_div);
  endfunction

  function automatic logic [31:0] m_read();
    int a, p, r;
    if (!sel) return 32'd0;
    a = int'(addr);
    p = (a / 32) % 8;
    r = (a / 4) % 8;
    if (a >= 256) begin
      if (r == 0) return m_div;
      if (r == 1) return m_ticks;
      return 32'd0;
    end
    if (p >= NP) return 32'd0;
    case (r)
      0: return m_out[p];
      1: return m_oe[p];
      2: return m_hist[S-1][p*W +: W];
      3: return m_ren[p];
      4: return m_fen[p];
      5: return m_st[p];
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] mk, clr;
    logic [NP*W-1:0] cur, prev, rise, fall;
    int a, p, r;
    bit tk, dw;
    if (!rst) begin
      for (int q = 0; q < NP; q++) begin
        m_out[q] = '0; m_oe[q] = '0; m_ren[q] = '0; m_fen[q] = '0; m_st[q] = '0;
      end
      for (int i = 0; i <= S; i++) m_hist[i] = '0;
      m_div = 32'(DIVR);
      m_ticks = 32'd0;
      m_k = 0;
      m_valid = 1'b1;
      return;
    end
    if (!m_valid) return;
    cur  = m_hist[S-1];
    prev = m_hist[S];
    rise = cur & ~prev;
    fall = ~cur & prev;
    tk = m_tick();
    dw = 1'b0;
    a = int'(addr);
    p = (a / 32) % 8;
    r = (a / 4) % 8;
    mk = lane_mask(wstrb);
    for (int q = 0; q < NP; q++) begin
      clr = 32'd0;
      if (sel && we && a < 256 && p == q && r == 5) clr = wdata & mk;
      m_st[q] = (m_st[q] & ~clr) | (rise[q*W +: W] & m_ren[q]) | (fall[q*W +: W] & m_fen[q]);
    end
    if (sel && we) begin
      if (a >= 256) begin
        if (r == 0) begin
          m_div = ((m_div & ~mk) | (wdata & mk)) & DIV_MASK;
          dw = 1'b1;
        end
      end else if (p < NP) begin
        case (r)
          0: m_out[p] = (m_out[p] & ~mk) | (wdata & mk);
          1: m_oe[p]  = (m_oe[p] & ~mk) | (wdata & mk);
          3: m_ren[p] = (m_ren[p] & ~mk) | (wdata & mk);
          4: m_fen[p] = (m_fen[p] & ~mk) | (wdata & mk);
          default: ;
        endcase
      end
    end
    if (tk) m_ticks = m_ticks + 32'd1;
    m_k = dw ? 0 : m_k + 1;
    for (int i = S; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = gpio_i;
  endtask

  task automatic compare();
    logic [NP*W-1:0] eo, eoe;
    bit eirq;
    eirq = 1'b0;
    for (int q = 0; q < NP; q++) begin
      eo[q*W +: W]  = m_out[q];
      eoe[q*W +: W] = m_oe[q];
      if (m_st[q] != '0) eirq = 1'b1;
    end
    check("gpio_o",  64'(gpio_o),  64'(eo));
    check("gpio_oe", 64'(gpio_oe), 64'(eoe));
    check("irq_o",   64'(irq_o),   64'(eirq));
    check("tick_o",  64'(tick_o),  64'(m_tick()));
    check("rdata",   64'(rdata),   64'(m_read()));
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) compare();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d; wstrb = s;
    step();
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [8:0] a, input logic [31:0] exp);
    sel = 1'b1; we = 1'b0; addr = a;
    #2;
    check(nm, 64'(rdata), 64'(exp));
    step();
    sel = 1'b0;
  endtask

  logic [31:0] t0, t1;

  initial begin
    rst = 1'b0; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0; wstrb = '0; gpio_i = '0;
    repeat (3) step();
    check("rst_gpio_o",  64'(gpio_o),  64'd0);
    check("rst_gpio_oe", 64'(gpio_oe), 64'd0);
    check("rst_irq",     64'(irq_o),   64'd0);
    check("rst_tick",    64'(tick_o),  64'd0);
    rst = 1'b1;
    rd("rst_div", 9'h100, 32'd2);

    // Full-word write to port1 OUT, then byte write into port0 OE lane 2.
    wr(9'h020, 32'hA5A5_0F0F, 4'b1111);
    check("p1_out_pins", 64'(gpio_o[63:32]), 64'hA5A5_0F0F);
    check("p0_out_pins", 64'(gpio_o[31:0]),  64'd0);
    rd("p1_out_read", 9'h020, 32'hA5A5_0F0F);
    wr(9'h006, 32'h3C3C_3C3C, 4'b0100);
    check("p0_oe_byte2", 64'(gpio_oe[31:0]), 64'h003C_0000);

    // Rise on port0 bit0: status appears on the third edge after the pad change.
    wr(9'h00C, 32'h1, 4'b1111);
    gpio_i[0] = 1'b1;
    step(); check("irq_lat_e1", 64'(irq_o), 64'd0);
    step(); check("irq_lat_e2", 64'(irq_o), 64'd0);
    step(); check("irq_lat_e3", 64'(irq_o), 64'd1);
    rd("p0_status_set", 9'h014, 32'h1);
    rd("p0_in", 9'h008, 32'h1);

    // Second rise coinciding with a W1C: the bit must survive.
    gpio_i[0] = 1'b0;
    repeat (4) step();
    gpio_i[0] = 1'b1;
    step(); step();
    wr(9'h014, 32'h1, 4'b1111);
    check("w1c_vs_set_irq", 64'(irq_o), 64'd1);
    rd("w1c_vs_set_st", 9'h014, 32'h1);
    wr(9'h014, 32'h1, 4'b1111);
    check("w1c_clear_irq", 64'(irq_o), 64'd0);
    rd("w1c_clear_st", 9'h014, 32'h0);

    // Fall on port1 bit5; W1C on the wrong byte lane must not clear it.
    wr(9'h030, 32'h20, 4'b1111);
    gpio_i[37] = 1'b1;
    repeat (4) step();
    check("fall_no_rise", 64'(irq_o), 64'd0);
    gpio_i[37] = 1'b0;
    repeat (3) step();
    check("fall_irq", 64'(irq_o), 64'd1);
    rd("p1_status", 9'h034, 32'h20);
    wr(9'h034, 32'h20, 4'b0010);
    rd("p1_status_lane", 9'h034, 32'h20);
    wr(9'h034, 32'h20, 4'b0001);
    check("p1_clear_irq", 64'(irq_o), 64'd0);

    // Divider: DIV=3 gives a pulse every fourth cycle; DIV=0 holds tick high.
    wr(9'h100, 32'd3, 4'b1111);
    sel = 1'b1; we = 1'b0; addr = 9'h104;
    #1 t0 = rdata;
    for (int i = 0; i < 8; i++) begin
      check("div3_tick", 64'(tick_o), 64'((i % 4) == 3));
      step();
    end
    #1 t1 = rdata;
    check("ticks_delta", 64'(t1 - t0), 64'd2);
    sel = 1'b0;
    wr(9'h100, 32'd0, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      check("div0_tick", 64'(tick_o), 64'd1);
      step();
    end

    // Reset with a write pending: reset wins and the write is lost.
    wr(9'h000, 32'h1234_5678, 4'b1111);
    wr(9'h100, 32'd5, 4'b1111);
    rst = 1'b0; sel = 1'b1; we = 1'b1; addr = 9'h000; wdata = 32'hFFFF_FFFF; wstrb = 4'b1111;
    step();
    check("mid_rst_gpio_o",  64'(gpio_o),  64'd0);
    check("mid_rst_gpio_oe", 64'(gpio_oe), 64'd0);
    check("mid_rst_irq",     64'(irq_o),   64'd0);
    check("mid_rst_tick",    64'(tick_o),  64'd0);
    rst = 1'b1; sel = 1'b0; we = 1'b0;
    rd("mid_rst_div", 9'h100, 32'd2);
    rd("mid_rst_out", 9'h000, 32'd0);

    // Unmapped locations read zero and absorb writes; addr[7:5] is ignored globally.
    rd("p3_read",   9'h060, 32'd0);
    rd("g5_read",   9'h114, 32'd0);
    rd("p0_reg6",   9'h018, 32'd0);
    rd("div_alias", 9'h1E0, 32'd2);
    wr(9'h060, 32'hFFFF_FFFF, 4'b1111);
    wr(9'h114, 32'hFFFF_FFFF, 4'b1111);
    wr(9'h104, 32'hFFFF_FFFF, 4'b1111);
    check("bad_wr_gpio_o",  64'(gpio_o),  64'd0);
    check("bad_wr_gpio_oe", 64'(gpio_oe), 64'd0);
    rd("bad_wr_div", 9'h100, 32'd2);
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mmio_gpio_ctrl.md
Name: mmio_gpio_ctrl

Overview:
Parametrised memory-mapped I/O controller that replaces the core's single hard-wired 32-bit output latch and fixed clock-divider counter. It provides NUM_PORTS independent ports, each with:
- output and output-enable registers
- synchronised inputs
- per-bit rise/fall edge detection with sticky W1C status and an interrupt line

It also provides a programmable tick divider. It sits on the core's data-memory side, selected by the store/load address decode, and answers loads combinationally so a single-cycle core can use it.

Parameters:
NUM_PORTS, 2, number of GPIO ports (1..8)
WIDTH, 32, bits per port (1..32); register bits above WIDTH read 0, writes ignored
SYNC_STAGES, 2, input synchroniser depth (>=2)
DIV_W, 24, tick divider width
DIV_RESET, 2, divider reload value after reset

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-low reset (rst==0 at a clk edge resets all state)
sel  in  1  access to this block this cycle
we  in  1  write strobe (valid with sel)
addr  in  9  byte address; addr[1:0] ignored
wdata  in  32  write data
wstrb  in  4  byte enables (sb=0001<<a, sh=0011<<a, sw=1111)
rdata  out  32  read data, combinational from addr; 0 when sel==0
gpio_i  in  NUM_PORTS*WIDTH  asynchronous pad inputs, port p at [p*WIDTH +: WIDTH]
gpio_o  out  NUM_PORTS*WIDTH  OUT registers
gpio_oe  out  NUM_PORTS*WIDTH  OE registers
irq_o  out  1  OR of (STATUS) over all ports, combinational
tick_o  out  1  one-cycle divider pulse

Behaviour:
- Address decode:
  - addr[8]==0 selects a port: p=addr[7:5], reg=addr[4:2].
  - addr[8]==1 selects a global register: reg=addr[4:2], addr[7:5] ignored.
  - p>=NUM_PORTS or an unlisted reg: read 0, write ignored.
- Port registers:
  - 0 OUT (RW)
  - 1 OE (RW)
  - 2 IN (RO, synchronised value)
  - 3 RISE_EN (RW)
  - 4 FALL_EN (RW)
  - 5 STATUS (RO; W1C)
- Global registers:
  - 0 DIV (RW, DIV_W bits)
  - 1 TICKS (RO, 32-bit free-running tick count)
- Writes:
  - Take effect at the clk edge where sel&&we&&rst; byte lanes are gated by wstrb.
  - W1C applies only to strobed bytes.
- Reads: no side effects; a read and a write to the same register in one cycle returns the pre-write value.
- Input path: SYNC_STAGES-flop synchroniser per bit, then one history flop. Edge detection uses the last synchroniser stage (cur) against the history flop (prev):
  - rise = cur&~prev
  - fall = ~cur&prev
  - Latency from a gpio_i change to STATUS set: SYNC_STAGES+1 edges.
- STATUS update per bit: next = (status & ~clr) | (rise&RISE_EN) | (fall&FALL_EN). A set and a W1C in the same cycle leave the bit set.
- Enable behaviour:
  - Disabling an enable does not clear existing status.
  - Enabling does not report edges that occurred earlier.
- Divider:
  - Counter runs 0..DIV. When counter==DIV: tick_o=1 for that cycle, counter wraps to 0 and TICKS increments.
  - DIV==0: tick_o is high every cycle.
  - A write to DIV zeroes the counter in the same edge.
  - TICKS wraps at 2^32 silently.
- Reset values (rst==0):
  - OUT, OE, RISE_EN, FALL_EN, STATUS, TICKS, counter = 0
  - Synchroniser and history flops = 0
  - DIV = DIV_RESET
  - gpio_o=0, gpio_oe=0, irq_o=0, tick_o=0
- Reset is dominant over a concurrent write. Pad edges present in the synchroniser at reset deassertion do not raise status unless they occur after reset (history flop also resets to 0, so a pad already high produces one rise edge; this is intended and documented).

Decomposition:
- Package gpio_pkg:
  - Register offset constants (REG_OUT..REG_STATUS, REG_DIV, REG_TICKS)
  - Address field positions
  - Enum typedef for the register select
- Sub-module gpio_port: one port's registers, synchroniser, edge detect and status. It is instantiated NUM_PORTS times via generate.
- Top level holds the decode, read mux, divider and irq OR.

Test Plan:
- Reset, then sw 0xA5A5_0F0F to port1 OUT (addr 0x020, wstrb 1111) -> gpio_o[63:32]=0xA5A50F0F next cycle; port0 unchanged; readback equals the written value.
- sb 0x3C to port0 OE byte 2 (addr 0x006, wstrb 0100) -> OE=0x003C0000; other bytes stay 0.
- RISE_EN[0]=1 and gpio_i[0] 0→1 -> STATUS[0]=1 and irq_o=1 exactly 3 edges later. W1C 0x1 in the same cycle as a second rise → stays 1. A later W1C → 0 and irq_o=0.
- Write DIV=3 -> tick_o pulses every 4 cycles and TICKS increments per pulse. Write DIV=0 -> tick_o held high.
- Pull rst low mid-sequence with sel&&we active -> all outputs 0 and DIV=2 after the edge; the write is discarded.
- Read port index 3 with NUM_PORTS=2, and global reg 5 -> rdata=0. Writes to them change nothing.
